ternary_mac_sequencer: RTL and testbench

//  Host-side initiator for the ternary MAC array. Buffers 8 input-vector byte pairs, loads the packed 2-bit ternary weights,
//  and drives the array's row/vector/weight inputs as gap-free 8-cycle bursts. Collects the 7 column sums on the next burst,
//  or on an all-zero flush burst, and returns them as a byte stream with valid/ready handshakes.

---
 rtl/ternary_pkg.sv | 16 +
 rtl/ternary_mac_sequencer_vec_pair_buffer.sv | 41 ++++
 rtl/ternary_mac_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ternary_mac_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared constants and FSM state type for the ternary MAC array host side.
package ternary_pkg;
    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    localparam int N_ROWS  = 8;
    localparam int N_COLS  = 7;
    localparam int W_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;
endpackage

// File: rtl/ternary_mac_sequencer_vec_pair_buffer.sv
// vec_pair_buffer: holds one pass worth of input pairs; written in order,
// read back by row index while the burst walks the rows.
module vec_pair_buffer
    import ternary_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = N_ROWS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     clear,
    input  logic [$clog2(DEPTH)-1:0] rd_row,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     almost_full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   cnt;

    assign full        = (cnt == (AW+1)'(DEPTH));
    assign almost_full = (cnt == (AW+1)'(DEPTH-1));
    assign rd_data     = mem[rd_row];

    // Clear only rewinds the write pointer; the contents stay readable so the
    // burst that triggered the clear can still walk them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (wr_en && !full) begin
            mem[cnt[AW-1:0]] <= wr_data;
            cnt              <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ternary_mac_sequencer.sv
// ternary_mac_sequencer: buffers input pairs and packed ternary weights, drives
// the MAC array in gap-free 8-row bursts, and streams the previous pass's
// column sums back out as bytes.
module ternary_mac_sequencer
    import ternary_pkg::*;
#(
    parameter int BitWidth = 8,
    parameter int OutLen   = N_COLS,
    parameter int NRows    = N_ROWS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_valid,
    input  logic [7:0]            w_data,
    output logic                  w_ready,
    input  logic                  in_valid,
    input  logic [2*BitWidth-1:0] in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [BitWidth-1:0]   out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [2:0]            mac_row,
    output logic                  mac_en,
    output logic [2*BitWidth-1:0] mac_vec,
    output logic [4*OutLen-1:0]   mac_w,
    input  logic [BitWidth-1:0]   mac_vec_out
);
    localparam logic [2:0] LAST_ROW = 3'(NRows-1);
    localparam logic [2:0] LAST_COL = 3'(OutLen-1);
    localparam logic [1:0] LAST_WB  = 2'(W_BYTES-1);

    state_t                state;
    logic                  pending;
    logic                  flush_lat;
    logic [1:0]            w_idx;
    logic [4*OutLen-1:0]   w_reg;
    logic [BitWidth-1:0]   res_mem [OutLen];
    logic [2:0]            rd_ptr;
    logic [3:0]            res_cnt;

    logic                  buf_full, buf_almost, buf_clear;
    logic [2:0]            rd_row;
    logic [2*BitWidth-1:0] rd_data;
    logic                  push, w_fire, pop, capture, fifo_empty;
    logic                  start_burst, start_flush;

    assign busy        = (state != IDLE) || buf_full;
    assign w_ready     = !busy;
    assign in_ready    = !busy;
    assign push        = in_valid && in_ready;
    assign w_fire      = w_valid && w_ready;
    assign fifo_empty  = (res_cnt == 4'd0);
    assign out_valid   = !fifo_empty;
    assign out_data    = res_mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    assign mac_w       = w_reg;

    // A full buffer wins over a latched flush so a flush that arrived with the
    // 8th pair is served after that pass, emitting its results.
    assign start_burst = (state == IDLE) && buf_full && fifo_empty;
    assign start_flush = (state == IDLE) && !buf_full && flush_lat && pending && fifo_empty;
    assign buf_clear   = start_burst;

    // Prefetch the row that will be presented on the next cycle.
    assign rd_row      = (state == IDLE) ? 3'd0 : mac_row + 3'd1;

    // The array presents the previous pass's column k while row k is driven.
    assign capture     = mac_en && pending && (mac_row <= LAST_COL);

    vec_pair_buffer #(.DW(2*BitWidth), .DEPTH(NRows)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (push),
        .wr_data     (in_data),
        .clear       (buf_clear),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
        .full        (buf_full),
        .almost_full (buf_almost)
    );

    // Weight bytes land little-endian; the 5th byte wraps onto byte 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_idx <= '0;
            w_reg <= '0;
        end else if (w_fire) begin
            case (w_idx)
                2'd0:    w_reg[7:0]   <= w_data;
                2'd1:    w_reg[15:8]  <= w_data;
                2'd2:    w_reg[23:16] <= w_data;
                default: w_reg[27:24] <= w_data[3:0];
            endcase
            w_idx <= (w_idx == LAST_WB) ? 2'd0 : w_idx + 2'd1;
        end
    end

    // Burst sequencer: mac_row parks at 7 with a zero vector between bursts so
    // the array accumulator holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mac_row <= 3'd7;
            mac_en  <= 1'b0;
            mac_vec <= '0;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_burst) begin
                        state   <= BURST;
                        mac_row <= 3'd0;
                        mac_en  <= 1'b1;
                        mac_vec <= rd_data;
                    end else if (start_flush) begin
                        state   <= FLUSH;
                        mac_row <= 3'd0;
                        mac_en  <= 1'b1;
                        mac_vec <= '0;
                    end
                end
                BURST, FLUSH: begin
                    if (mac_row == LAST_ROW) begin
                        state   <= IDLE;
                        mac_row <= 3'd7;
                        mac_en  <= 1'b0;
                        mac_vec <= '0;
                        pending <= (state == BURST);
                    end else begin
                        mac_row <= mac_row + 3'd1;
                        mac_vec <= (state == BURST) ? rd_data : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flush request latch; a flush with nothing pending (and no pass about to
    // start) is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_lat <= 1'b0;
        end else if (start_flush) begin
            flush_lat <= 1'b0;
        end else if (flush && (state != FLUSH) && (pending || buf_full || (push && buf_almost))) begin
            flush_lat <= 1'b1;
        end else if ((state == IDLE) && flush_lat && !pending && !buf_full) begin
            flush_lat <= 1'b0;
        end
    end

    // Result FIFO: slot k is written on row k, drained in column order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            res_cnt <= '0;
            for (int i = 0; i < OutLen; i++) res_mem[i] <= '0;
        end else begin
            if (capture) res_mem[mac_row] <= mac_vec_out;
            if (pop) rd_ptr <= (rd_ptr == LAST_COL) ? 3'd0 : rd_ptr + 3'd1;
            if (capture && !pop)      res_cnt <= res_cnt + 4'd1;
            else if (!capture && pop) res_cnt <= res_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_ternary_mac_sequencer.sv
// Bench for ternary_mac_sequencer: behavioural MAC array on the array side,
// a pass-level reference model and an output scoreboard on the host side.
module tb_ternary_mac_sequencer;
    localparam int TMO = 5000;

    logic        clk = 0;
    logic        rst = 0;
    logic        w_valid = 0;
    logic [7:0]  w_data = 0;
    logic        w_ready;
    logic        in_valid = 0;
    logic [15:0] in_data = 0;
    logic        in_ready;
    logic        flush = 0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 0;
    logic        busy;
    logic [2:0]  mac_row;
    logic        mac_en;
    logic [15:0] mac_vec;
    logic [27:0] mac_w;
    logic [7:0]  mac_vec_out;

    ternary_mac_sequencer dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy),
        .mac_row(mac_row), .mac_en(mac_en), .mac_vec(mac_vec), .mac_w(mac_w),
        .mac_vec_out(mac_vec_out)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tv(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    // Behavioural MAC array: row 0 latches the finished pass and restarts.
    logic [7:0] acc  [7] = '{default: 8'h00};
    logic [7:0] prev [7] = '{default: 8'h00};
    always @(posedge clk) begin
        for (int c = 0; c < 7; c++) begin
            int p;
            p = tv(mac_w[2*c +: 2]) * $signed(mac_vec[7:0])
              + tv(mac_w[14+2*c +: 2]) * $signed(mac_vec[15:8]);
            if (mac_row == 3'd0) begin
                prev[c] <= acc[c];
                acc[c]  <= 8'(p);
            end else begin
                acc[c]  <= acc[c] + 8'(p);
            end
        end
    end
    assign mac_vec_out = (mac_row == 3'd0) ? acc[0] : (mac_row == 3'd7) ? 8'h00 : prev[mac_row];

    // Reference model at pass granularity.
    logic [7:0] wb [4];
    int         widx = 0;
    bit         pend = 0;
    logic [7:0] last [7];
    logic [7:0] expq [$];
    logic [7:0] pa [8];
    logic [7:0] pb [8];
    logic [7:0] rx [7];
    int         col = 0;
    bit         stall = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) wb[i] = 8'h00;
        widx = 0; pend = 0; expq.delete();
    endtask

    task automatic model_pass();
        logic [27:0] w;
        if (pend) for (int c = 0; c < 7; c++) expq.push_back(last[c]);
        w = {wb[3][3:0], wb[2], wb[1], wb[0]};
        for (int c = 0; c < 7; c++) begin
            int s = 0;
            for (int r = 0; r < 8; r++)
                s += tv(w[2*c +: 2]) * $signed(pa[r]) + tv(w[14+2*c +: 2]) * $signed(pb[r]);
            last[c] = 8'(s);
        end
        pend = 1;
    endtask

    task automatic model_flush();
        if (pend) for (int c = 0; c < 7; c++) expq.push_back(last[c]);
        pend = 0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        w_valid = 1; w_data = b;
        while (!w_ready && n < TMO) begin @(negedge clk); n++; end
        if (!w_ready) chk("w_ready_timeout", 0, 1);
        @(posedge clk); #1;
        w_valid = 0;
        wb[widx] = b; widx = (widx + 1) % 4;
    endtask

    task automatic load_w(input logic [31:0] w);
        for (int i = 0; i < 4; i++) load_byte(w[8*i +: 8]);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit fl);
        int n = 0;
        @(negedge clk);
        in_valid = 1; in_data = {b, a};
        while (!in_ready && n < TMO) begin @(negedge clk); n++; end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        flush = fl;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
    endtask

    task automatic do_pass(input bit fl);
        model_pass();
        if (fl) model_flush();
        for (int r = 0; r < 8; r++) send_pair(pa[r], pb[r], fl && (r == 7));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < TMO) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((expq.size() != 0 || busy) && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) chk("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_flush();
        wait_idle();
        @(negedge clk);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        model_flush();
        wait_drain();
    endtask

    task automatic rand_pairs();
        for (int r = 0; r < 8; r++) begin
            pa[r] = 8'($urandom);
            pb[r] = 8'($urandom);
        end
    endtask

    task automatic const_pairs(input logic [7:0] a, input logic [7:0] b);
        for (int r = 0; r < 8; r++) begin pa[r] = a; pb[r] = b; end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_w_ready"},   w_ready, 1);
        chk({tag, "_in_ready"},  in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_mac_row"},   mac_row, 7);
        chk({tag, "_mac_en"},    mac_en, 0);
        chk({tag, "_mac_vec"},   mac_vec, 0);
        chk({tag, "_mac_w"},     mac_w, 0);
    endtask

    // Output scoreboard with random back-pressure and hold-stability checks.
    initial begin
        bit hold = 0;
        logic [7:0] held = 0;
        bit r;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0; col = 0; out_ready = 0;
            end else begin
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, held);
                end
                r = !stall && ($urandom_range(0, 3) != 0);
                out_ready = r;
                if (out_valid && r) begin
                    if (expq.size() == 0) chk("spurious_out", 1, 0);
                    else chk("out_byte", out_data, expq.pop_front());
                    rx[col] = out_data;
                    col = (col == 6) ? 0 : col + 1;
                end
                hold = out_valid && !r;
                held = out_data;
            end
        end
    end

    initial begin
        int n;
        model_reset();
        #1 rst = 1;
        #1 chk_reset_outs("por");
        repeat (3) @(negedge clk);
        rst = 0;

        // Directed sums: +1/+1, -1/+1, and modulo wrap.
        load_w(32'h0004001); const_pairs(8'd1, 8'd2); do_pass(0); do_flush();
        chk("t1_col0", rx[0], 8'h18);
        chk("t1_col3", rx[3], 8'h00);
        load_w(32'h001000C); const_pairs(8'd5, 8'd3); do_pass(0); do_flush();
        chk("t2_col1", rx[1], 8'hF0);
        chk("t2_col0", rx[0], 8'h00);
        load_w(32'h0040010); const_pairs(8'd100, 8'd100); do_pass(0); do_flush();
        chk("t3_col2", rx[2], 8'h40);

        // Back-to-back passes; full buffer and busy block further input.
        rand_pairs(); do_pass(0);
        chk("full_in_ready", in_ready, 0);
        chk("full_w_ready", w_ready, 0);
        wait_idle();
        @(negedge clk);
        chk("pass1_no_out", out_valid, 0);
        stall = 1;
        rand_pairs(); do_pass(0);
        n = 0;
        while (!(mac_en && mac_row == 3'd3) && n < TMO) begin @(negedge clk); n++; end
        chk("pass2_row3_seen", n < TMO, 1);
        chk("pass2_out_valid", out_valid, 1);
        repeat (15) @(negedge clk);
        stall = 0;
        do_flush();

        // Flush together with the 8th pair, and a 5-byte weight load.
        rand_pairs(); do_pass(1); wait_drain();
        for (int i = 0; i < 5; i++) load_byte(8'($urandom));
        rand_pairs(); do_pass(1); wait_drain();

        // Reset in the middle of a burst.
        load_w($urandom); rand_pairs(); do_pass(0);
        n = 0;
        while (!(mac_en && mac_row == 3'd4) && n < TMO) begin @(negedge clk); n++; end
        chk("row4_seen", n < TMO, 1);
        rst = 1;
        #1 chk_reset_outs("mid");
        model_reset();
        @(negedge clk);
        rst = 0;
        do_flush();
        chk("drop_flush_busy", busy, 0);
        chk("drop_flush_en", mac_en, 0);
        load_w($urandom); rand_pairs(); do_pass(0);
        wait_idle();
        @(negedge clk);
        chk("post_rst_no_out", out_valid, 0);
        do_flush();

        // Randomized mix of passes, weight reloads and flushes.
        for (int it = 0; it < 12; it++) begin
            bit fl;
            if ($urandom_range(0, 1) == 1) load_w($urandom);
            rand_pairs();
            fl = ($urandom_range(0, 3) == 0);
            do_pass(fl);
            if (fl) wait_drain();
            else if ($urandom_range(0, 2) == 0) do_flush();
        end
        do_flush();
        chk("final_queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
